// File: rtl/render_stream_out.sv
// Output stage of the ray-marcher: buffers LANES-wide pixel beats and serialises them to a
// single-pixel ready/valid stream with frame markers. Optional stats: RENDER_STREAM_STATS_EN.
module render_stream_out #(
  parameter int unsigned COLOR_W      = 24,
  parameter int unsigned LANES        = 2,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst_gen,
  input  logic                     resync,
  input  logic [LANES*COLOR_W-1:0] shade_in,
  input  logic                     valid_in,
  output logic                     stall_out,
  output logic [COLOR_W-1:0]       m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     frame_done,
  output logic                     overflow
`ifdef RENDER_STREAM_STATS_EN
  ,
  output logic [15:0]              frame_count,
  output logic [15:0]              drop_count
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [CW-1:0] DepthC    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ThreshC   = CW'(AFULL_THRESH);
  localparam logic [LW-1:0] LastLane  = LW'(LANES - 1);
  localparam logic [XW-1:0] XLast     = XW'(H_RES - 1);
  localparam logic [YW-1:0] YLast     = YW'(V_RES - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                   state_q;
  logic [LANES*COLOR_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic [LW-1:0]            lane_q;
  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic                     stall_q, ovf_q;

  logic                     live, hs, pop, wr, drop, x_last, y_last;
  logic [LANES*COLOR_W-1:0] rd_beat;
  logic [COLOR_W-1:0]       lane_pix;

  // Reset and resync both suppress every same-cycle write and handshake.
  assign live   = !rst_gen && !resync;
  assign hs     = m_valid && m_ready && live;
  assign pop    = hs && (lane_q == LastLane);
  assign wr     = valid_in && live && ((count_q < DepthC) || pop);
  assign drop   = valid_in && live && !((count_q < DepthC) || pop);
  assign x_last = (x_q == XLast);
  assign y_last = (y_q == YLast);

  always_comb begin
    count_d = count_q;
    if (wr && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  assign rd_beat = mem[rd_ptr_q];

  always_comb begin
    lane_pix = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i)) lane_pix = rd_beat[i*COLOR_W +: COLOR_W];
    end
  end

  assign m_valid    = (state_q == StStream);
  assign m_data     = m_valid ? lane_pix : '0;
  assign m_sof      = m_valid && (x_q == '0) && (y_q == '0);
  assign m_eol      = m_valid && x_last;
  assign frame_done = hs && x_last && y_last;
  assign stall_out  = stall_q;
  assign overflow   = ovf_q;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= shade_in;
  end

  always_ff @(posedge clk) begin
    if (rst_gen || resync) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      stall_q  <= 1'b0;
      if (rst_gen) ovf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= (count_d != '0) ? StStream : StIdle;
      stall_q <= (count_q >= ThreshC);
      if (wr)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) ovf_q    <= 1'b1;
      if (hs) begin
        lane_q <= pop ? '0 : lane_q + 1'b1;
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

`ifdef RENDER_STREAM_STATS_EN
  // Frame count wraps; drop count saturates. Only a full reset clears them.
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_render_stream_out.sv
// Self-checking bench for render_stream_out: directed scenarios plus randomized traffic
// checked against a pixel-queue reference model.
module tb_render_stream_out;
  localparam int CW = 24;
  localparam int L  = 2;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 16;
  localparam int T  = 12;
  localparam int HV = H * V;

  logic            clk = 1'b0;
  logic            rst_gen, resync, valid_in, m_ready;
  logic [L*CW-1:0] shade_in;
  logic            stall_out, m_valid, m_sof, m_eol, frame_done, overflow;
  logic [CW-1:0]   m_data;
`ifdef RENDER_STREAM_STATS_EN
  logic [15:0]     frame_count, drop_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  render_stream_out #(
    .COLOR_W(CW), .LANES(L), .H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .AFULL_THRESH(T)
  ) dut (
    .clk(clk), .rst_gen(rst_gen), .resync(resync), .shade_in(shade_in), .valid_in(valid_in),
    .stall_out(stall_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done), .overflow(overflow)
`ifdef RENDER_STREAM_STATS_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  // Reference model: a queue of pending pixels; beat occupancy is the pixel count rounded up.
  logic [CW-1:0] pq[$];
  int  tot;
  bit  ovf_m, stall_m;
  int  frames_m, drops_m;

  always @(posedge clk) begin : model
    int occ;
    bit hsm, popm;
    if (rst_gen) begin
      pq.delete(); tot = 0; ovf_m = 0; stall_m = 0; frames_m = 0; drops_m = 0;
    end else if (resync) begin
      pq.delete(); tot = 0; stall_m = 0;
    end else begin
      occ     = (pq.size() + L - 1) / L;
      hsm     = (pq.size() != 0) && m_ready;
      popm    = hsm && ((pq.size() % L) == (1 % L));
      stall_m = (occ >= T);
      if (hsm) begin
        if (tot % HV == HV - 1) frames_m = (frames_m + 1) & 16'hFFFF;
        void'(pq.pop_front());
        tot++;
      end
      if (valid_in) begin
        if (occ < D || popm) begin
          for (int i = 0; i < L; i++) pq.push_back(shade_in[i*CW +: CW]);
        end else begin
          ovf_m = 1;
          if (drops_m < 65535) drops_m++;
        end
      end
    end
  end

  function automatic bit e_valid();
    return pq.size() != 0;
  endfunction
  function automatic logic [CW-1:0] e_data();
    return (pq.size() != 0) ? pq[0] : '0;
  endfunction

  function automatic logic [L*CW-1:0] rnd_beat();
    return (L*CW)'({$urandom(), $urandom()});
  endfunction

  task automatic pulse_resync();
    @(negedge clk);
    resync = 1; valid_in = 0;
    @(negedge clk);
    resync = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_gen = 1; valid_in = 0; m_ready = 0; resync = 0;
    repeat (2) @(negedge clk);
    rst_gen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (m_valid !== 0)    begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== '0)    begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    total++; if (m_sof !== 0 || m_eol !== 0 || frame_done !== 0)
      begin bad++; $display("FAIL reset_markers got=%b%b%b exp=000", m_sof, m_eol, frame_done); end
    total++; if (stall_out !== 0 || overflow !== 0)
      begin bad++; $display("FAIL reset_flags got=%b%b exp=00", stall_out, overflow); end
  endtask

  task automatic test_latency();
    logic [L*CW-1:0] b;
    b = rnd_beat();
    @(negedge clk);
    m_ready = 1; valid_in = 1; shade_in = b;
    #1;
    total++; if (m_valid !== 0) begin bad++; $display("FAIL lat_pre_valid got=%b exp=0", m_valid); end
    @(negedge clk);
    valid_in = 0;
    #1;
    total++; if (m_valid !== 1 || m_data !== b[CW-1:0] || m_sof !== 1)
      begin bad++; $display("FAIL lat_lane0 got=%b/%h/%b exp=1/%h/1", m_valid, m_data, m_sof, b[CW-1:0]); end
    @(negedge clk); #1;
    total++; if (m_valid !== 1 || m_data !== b[2*CW-1:CW] || m_sof !== 0)
      begin bad++; $display("FAIL lat_lane1 got=%b/%h/%b exp=1/%h/0", m_valid, m_data, m_sof, b[2*CW-1:CW]); end
    @(negedge clk); #1;
    total++; if (m_valid !== 0) begin bad++; $display("FAIL lat_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] px[$];
    logic [L*CW-1:0] b;
    pulse_resync();
    m_ready = 0;
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      b = rnd_beat(); valid_in = 1; shade_in = b;
      for (int i = 0; i < L; i++) px.push_back(b[i*CW +: CW]);
      #1;
      if (k > 0) begin
        total++; if (m_valid !== 1 || m_data !== px[0])
          begin bad++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/%h", k, m_valid, m_data, px[0]); end
      end
    end
    @(negedge clk);
    valid_in = 0;
    #1;
    total++; if (stall_out !== 0) begin bad++; $display("FAIL bp_stall_early got=%b exp=0", stall_out); end
    @(negedge clk); #1;
    total++; if (stall_out !== 1 || stall_out !== stall_m)
      begin bad++; $display("FAIL bp_stall got=%b exp=1", stall_out); end
    total++; if (m_data !== px[0]) begin bad++; $display("FAIL bp_hold_end got=%h exp=%h", m_data, px[0]); end
    for (int k = 0; k < T * L; k++) begin
      @(negedge clk);
      m_ready = 1;
      #1;
      total++; if (m_valid !== 1 || m_data !== px[k])
        begin bad++; $display("FAIL bp_drain k=%0d got=%b/%h exp=1/%h", k, m_valid, m_data, px[k]); end
    end
    @(negedge clk); #1;
    total++; if (m_valid !== 0) begin bad++; $display("FAIL bp_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_full_pop();
    logic [CW-1:0] px[$];
    logic [L*CW-1:0] b;
    do_reset();
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      b = rnd_beat(); valid_in = 1; shade_in = b;
      for (int i = 0; i < L; i++) px.push_back(b[i*CW +: CW]);
    end
    @(negedge clk);
    valid_in = 0; m_ready = 1;
    @(negedge clk);
    b = rnd_beat(); valid_in = 1; shade_in = b;
    for (int i = 0; i < L; i++) px.push_back(b[i*CW +: CW]);
    @(negedge clk);
    valid_in = 0; m_ready = 0;
    #1;
    total++; if (overflow !== 0) begin bad++; $display("FAIL fp_overflow got=%b exp=0", overflow); end
    total++; if (stall_out !== 1) begin bad++; $display("FAIL fp_stall got=%b exp=1", stall_out); end
    for (int k = L; k < (D + 1) * L; k++) begin
      @(negedge clk);
      m_ready = 1;
      #1;
      total++; if (m_valid !== 1 || m_data !== px[k])
        begin bad++; $display("FAIL fp_drain k=%0d got=%b/%h exp=1/%h", k, m_valid, m_data, px[k]); end
    end
    @(negedge clk); #1;
    total++; if (m_valid !== 0) begin bad++; $display("FAIL fp_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_overflow();
    pulse_resync();
    m_ready = 0;
    for (int k = 0; k < D + 1; k++) begin
      @(negedge clk);
      valid_in = 1; shade_in = rnd_beat();
      #1;
      if (k == D) begin
        total++; if (overflow !== 0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    @(negedge clk);
    valid_in = 0;
    #1;
    total++; if (overflow !== 1 || overflow !== ovf_m)
      begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    pulse_resync();
    #1;
    total++; if (overflow !== 1) begin bad++; $display("FAIL ovf_resync_hold got=%b exp=1", overflow); end
    total++; if (m_valid !== 0) begin bad++; $display("FAIL ovf_resync_valid got=%b exp=0", m_valid); end
  endtask

  task automatic test_frame_markers();
    logic [CW-1:0] px[$];
    logic [L*CW-1:0] b;
    pulse_resync();
    m_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b = rnd_beat(); valid_in = 1; shade_in = b;
      for (int i = 0; i < L; i++) px.push_back(b[i*CW +: CW]);
    end
    @(negedge clk);
    valid_in = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m_ready = 1;
      #1;
      total++; if (m_data !== px[k] || m_eol !== (k % H == H - 1) || m_sof !== (k % HV == 0) ||
                   frame_done !== (k == HV - 1))
        begin bad++; $display("FAIL frame k=%0d got=%h sof=%b eol=%b fd=%b exp=%h", k, m_data,
                              m_sof, m_eol, frame_done, px[k]); end
    end
    @(negedge clk);
    m_ready = 0;
  endtask

  task automatic test_random();
    pulse_resync();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      valid_in = ($urandom % 3 == 0);
      shade_in = rnd_beat();
      m_ready  = (c < 400) ? ($urandom % 3 == 0) : ($urandom % 4 != 0);
      resync   = ($urandom % 97 == 0);
      #1;
      total++; if (m_valid !== e_valid() || m_data !== e_data())
        begin bad++; $display("FAIL rand_data c=%0d got=%b/%h exp=%b/%h", c, m_valid, m_data,
                              e_valid(), e_data()); end
      total++; if (m_sof !== (e_valid() && tot % HV == 0) || m_eol !== (e_valid() && tot % H == H - 1))
        begin bad++; $display("FAIL rand_markers c=%0d got=%b%b tot=%0d", c, m_sof, m_eol, tot); end
      total++; if (frame_done !== (e_valid() && m_ready && !resync && tot % HV == HV - 1))
        begin bad++; $display("FAIL rand_frame_done c=%0d got=%b", c, frame_done); end
      total++; if (stall_out !== stall_m || overflow !== ovf_m)
        begin bad++; $display("FAIL rand_flags c=%0d got=%b%b exp=%b%b", c, stall_out, overflow,
                              stall_m, ovf_m); end
    end
    @(negedge clk);
    resync = 0; valid_in = 0; m_ready = 0;
  endtask

`ifdef RENDER_STREAM_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < D + 2; k++) begin
      @(negedge clk);
      valid_in = 1; shade_in = rnd_beat();
    end
    pulse_resync();
    m_ready = 1;
    for (int k = 0; k < 3 * HV / L; k++) begin
      @(negedge clk);
      valid_in = 1; shade_in = rnd_beat();
    end
    @(negedge clk);
    valid_in = 0;
    repeat (3 * HV) @(negedge clk);
    #1;
    total++; if (frame_count !== 16'd3 || frame_count !== 16'(frames_m))
      begin bad++; $display("FAIL stats_frames got=%0d exp=3", frame_count); end
    total++; if (drop_count !== 16'd2 || drop_count !== 16'(drops_m))
      begin bad++; $display("FAIL stats_drops got=%0d exp=2", drop_count); end
    pulse_resync();
    #1;
    total++; if (frame_count !== 16'd3 || drop_count !== 16'd2)
      begin bad++; $display("FAIL stats_resync got=%0d/%0d exp=3/2", frame_count, drop_count); end
  endtask
`endif

  initial begin
    rst_gen = 1; resync = 0; valid_in = 0; m_ready = 0; shade_in = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_full_pop();
    test_overflow();
    test_frame_markers();
    test_random();
`ifdef RENDER_STREAM_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
